// File: rtl/traffic_light_fsm.sv
// Intersection phase sequencer: drives the lights and arms the downstream Timer once per phase.
// Advances one cycle after an accepted Expired; the Timer gives no backpressure, and Expired is ignored for two cycles after each load.
module traffic_light_fsm #(
  parameter int unsigned T_BASE = 6,
  parameter int unsigned T_EXT  = 3,
  parameter int unsigned T_YEL  = 2
) (
  input  logic       clk,
  input  logic       Reset_n,
  input  logic       Sensor,
  input  logic       Walk_Request,
  input  logic       Expired,
  output logic       Start_Timer,
  output logic [3:0] Value,
  output logic [2:0] Main_Light,
  output logic [2:0] Side_Light,
  output logic       Walk_Light,
  output logic [2:0] Phase
);

  localparam logic [3:0] C_BASE = (T_BASE == 0) ? 4'd1 : 4'(T_BASE);
  localparam logic [3:0] C_EXT  = (T_EXT  == 0) ? 4'd1 : 4'(T_EXT);
  localparam logic [3:0] C_YEL  = (T_YEL  == 0) ? 4'd1 : 4'(T_YEL);

  localparam logic [2:0] L_RED = 3'b100;
  localparam logic [2:0] L_YEL = 3'b010;
  localparam logic [2:0] L_GRN = 3'b001;

  typedef enum logic [2:0] {
    MAIN_GRN = 3'd0,
    MAIN_YEL = 3'd1,
    WALK     = 3'd2,
    SIDE_GRN = 3'd3,
    SIDE_EXT = 3'd4,
    SIDE_YEL = 3'd5
  } phase_e;

  phase_e     r_phase;
  logic       r_armed;
  logic       r_start;
  logic       r_guard;
  logic       r_walk_pend;
  logic [3:0] r_value;
  logic [2:0] r_main;
  logic [2:0] r_side;
  logic       r_walk;

  phase_e     w_nxt_phase;
  logic       w_adv;
  logic       w_load;
  logic       w_walk_pend_nxt;
  logic [3:0] w_value;
  logic [2:0] w_main;
  logic [2:0] w_side;
  logic       w_walk;

  // Not armed yet, or inside the load cycle / the cycle after: a high Expired is stale.
  assign w_adv = Expired & r_armed & ~r_start & ~r_guard;

  always_comb begin
    w_nxt_phase = r_phase;
    w_load      = 1'b0;
    case (r_phase)
      MAIN_GRN: if (w_adv) begin w_nxt_phase = MAIN_YEL; w_load = 1'b1; end
      MAIN_YEL: if (w_adv) begin
        w_nxt_phase = r_walk_pend ? WALK : SIDE_GRN;
        w_load      = 1'b1;
      end
      WALK:     if (w_adv) begin w_nxt_phase = SIDE_GRN; w_load = 1'b1; end
      SIDE_GRN: if (w_adv) begin
        w_nxt_phase = Sensor ? SIDE_EXT : SIDE_YEL;
        w_load      = 1'b1;
      end
      SIDE_EXT: if (w_adv) begin w_nxt_phase = SIDE_YEL; w_load = 1'b1; end
      SIDE_YEL: if (w_adv) begin w_nxt_phase = MAIN_GRN; w_load = 1'b1; end
      default: begin
        w_nxt_phase = MAIN_GRN;
        w_load      = 1'b1;
      end
    endcase
    if (!r_armed) begin
      w_load = 1'b1;
    end
  end

  always_comb begin
    w_walk_pend_nxt = r_walk_pend | (Walk_Request & (r_phase != WALK));
    if (w_load && (w_nxt_phase == WALK)) begin
      w_walk_pend_nxt = 1'b0;
    end
  end

  // Outputs are decoded from the next phase so they land in the same cycle as the phase register.
  always_comb begin
    w_main  = L_RED;
    w_side  = L_RED;
    w_walk  = 1'b0;
    w_value = C_BASE;
    case (w_nxt_phase)
      MAIN_GRN: begin w_main = L_GRN; w_value = C_BASE; end
      MAIN_YEL: begin w_main = L_YEL; w_value = C_YEL;  end
      WALK:     begin w_walk = 1'b1;  w_value = C_EXT;  end
      SIDE_GRN: begin w_side = L_GRN; w_value = C_BASE; end
      SIDE_EXT: begin w_side = L_GRN; w_value = C_EXT;  end
      SIDE_YEL: begin w_side = L_YEL; w_value = C_YEL;  end
      default: begin
        w_main  = L_RED;
        w_side  = L_RED;
        w_walk  = 1'b0;
        w_value = C_BASE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge Reset_n) begin
    if (!Reset_n) begin
      r_phase     <= MAIN_GRN;
      r_armed     <= 1'b0;
      r_start     <= 1'b0;
      r_guard     <= 1'b0;
      r_walk_pend <= 1'b0;
      r_value     <= C_BASE;
      r_main      <= L_GRN;
      r_side      <= L_RED;
      r_walk      <= 1'b0;
    end else begin
      r_phase     <= w_nxt_phase;
      r_armed     <= 1'b1;
      r_start     <= w_load;
      r_guard     <= r_start;
      r_walk_pend <= w_walk_pend_nxt;
      r_value     <= w_value;
      r_main      <= w_main;
      r_side      <= w_side;
      r_walk      <= w_walk;
    end
  end

  assign Start_Timer = r_start;
  assign Value       = r_value;
  assign Main_Light  = r_main;
  assign Side_Light  = r_side;
  assign Walk_Light  = r_walk;
  assign Phase       = r_phase;

endmodule
